pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 6'd0, SHALL be the PC loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFC00_0000, SHALL be the instruction word that halts fetch.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 PCJout  in  6  SHALL be the taken conditional-jump target from the CJump stage.
REQ-006 Redirect  in  1  SHALL qualify PCJout (Branch & Zero taken) for one cycle.
REQ-007 ImemReq  out  1  SHALL be the instruction-memory read request.
REQ-008 ImemAddr  out  6  SHALL be the byte address being fetched.
REQ-009 ImemAck  in  1  SHALL signal that ImemData is valid for the current request.
REQ-010 ImemData  in  32  SHALL be the instruction-memory read data.
REQ-011 Instr  out  32  SHALL be the held instruction presented to decode.
REQ-012 InstrValid  out  1  SHALL mark Instr and PCNext as valid.
REQ-013 InstrReady  in  1  SHALL be decode's acceptance of Instr.
REQ-014 PCNext  out  6  SHALL be the fetched instruction's address + 4, the PCNext feeding CJump.
REQ-015 Halted  out  1  SHALL indicate fetch has stopped on HALT_WORD.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, HALT; all outputs registered.
REQ-017 IDLE SHALL go to FETCH on the first clock edge after rst_n deasserts.
REQ-018 FETCH SHALL drive ImemReq=1, ImemAddr=PC, and wait indefinitely for ImemAck.
REQ-019 FETCH with ImemAck SHALL capture Instr=ImemData, set PCNext=PC+4, set InstrValid=1, advance PC to PC+4, and enter HOLD.
REQ-020 All PC arithmetic SHALL be 6-bit modulo 64 (PC 60 + 4 = 0), with no overflow flag.
REQ-021 HOLD SHALL keep ImemReq=0 and Instr/PCNext/InstrValid stable until InstrReady=1.
REQ-022 HOLD with InstrReady=1 SHALL clear InstrValid next cycle and return to FETCH, unless Instr==HALT_WORD, in which case it SHALL enter HALT.
REQ-023 Minimum throughput SHALL be one instruction per two cycles, with fetch-to-valid latency of one cycle after ImemAck.
REQ-024 HALT SHALL hold ImemReq=0, InstrValid=0, Halted=1, and ignore Redirect; it SHALL exit only through reset.
REQ-025 Redirect=1 in FETCH or HOLD SHALL load PC=PCJout, clear InstrValid, and enter FETCH next cycle.
REQ-026 Redirect SHALL take priority over a same-cycle ImemAck, which is discarded (no capture, no PC+4).
REQ-027 Redirect SHALL take priority over a same-cycle InstrReady; HALT_WORD SHALL NOT be honoured in that cycle.
REQ-028 ImemAck outside FETCH SHALL be ignored.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, PC=RESET_PC, ImemReq=0, ImemAddr=RESET_PC, Instr=0, InstrValid=0, PCNext=0, Halted=0.
REQ-030 Reset mid-fetch or mid-hold SHALL abandon the transaction; a late ImemAck after reset SHALL be ignored until FETCH.

Structure
REQ-031 State encoding, PC width (6), and HALT_WORD default SHALL live in the shared cpu package.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 Reset release; ImemAck with 32'h2002_0005 one cycle after ImemReq; InstrReady=1 -> ImemAddr=0, Instr=32'h2002_0005, PCNext=4, next ImemAddr=4.
REQ-034 InstrReady=0 for 5 cycles in HOLD -> Instr/PCNext stable, ImemReq=0; InstrReady=1 -> FETCH at PC+4.
REQ-035 Redirect=1, PCJout=6'd52 in the same cycle as ImemAck -> data discarded, next ImemAddr=52, InstrValid=0.
REQ-036 Fetch at PC=60 -> PCNext=0, next ImemAddr=0.
REQ-037 Fetch HALT_WORD and accept it -> Halted=1, ImemReq=0 permanently; Redirect ignored; rst_n pulse -> ImemAddr=RESET_PC.
REQ-038 rst_n asserted asynchronously mid-HOLD -> InstrValid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/pc_fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: PC width, FSM encoding and the
// halt instruction word.
package pc_fetch_stage_pkg;

   localparam int PC_W = 6;

   typedef logic [PC_W-1:0] pc_t;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   // Every fetch-stage output comes straight from one of these registers.
   typedef struct packed {
      fetch_state_t state;
      pc_t          pc;
      logic         imem_req;
      logic [31:0]  instr;
      logic         instr_valid;
      pc_t          pc_next;
      logic         halted;
   } fetch_regs_t;

   // Sequential-instruction increment; wraps modulo 64 by construction.
   function automatic pc_t pc_inc(input pc_t pc);
      return pc + pc_t'(4);
   endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/ack, decode handshake and the
// CJump redirect path.
interface pc_fetch_stage_if;
   import pc_fetch_stage_pkg::*;

   pc_t         pcj_out;
   logic        redirect;
   logic        imem_req;
   pc_t         imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   pc_t         pc_next;
   logic        halted;

   modport master (
      input  pcj_out, redirect, imem_ack, imem_data, instr_ready,
      output imem_req, imem_addr, instr, instr_valid, pc_next, halted
   );

   modport slave (
      output pcj_out, redirect, imem_ack, imem_data, instr_ready,
      input  imem_req, imem_addr, instr, instr_valid, pc_next, halted
   );

endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: requests one word per instruction, holds it for
// decode, follows CJump redirects and stops for good on the halt word.
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter pc_t         RESET_PC  = 6'd0,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   pc_fetch_stage_if.master fetch
);

   localparam fetch_regs_t RESET_REGS = '{
      state:       ST_IDLE,
      pc:          RESET_PC,
      imem_req:    1'b0,
      instr:       32'd0,
      instr_valid: 1'b0,
      pc_next:     '0,
      halted:      1'b0
   };

   fetch_regs_t r;
   fetch_regs_t r_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= RESET_REGS;
      end else begin
         // NOTE: non-blocking, so every register samples pre-edge values.
         r <= r_n;
      end
   end

   always_comb begin
      // NOTE: start from the current values so every path assigns r_n and no latch is inferred.
      r_n = r;

      // A redirect wins over any same-cycle ack or decode acceptance.
      if ((r.state == ST_FETCH || r.state == ST_HOLD) && fetch.redirect) begin
         r_n.state       = ST_FETCH;
         r_n.pc          = fetch.pcj_out;
         r_n.imem_req    = 1'b1;
         r_n.instr_valid = 1'b0;
      end else begin
         unique case (r.state)
            ST_IDLE: begin
               r_n.state    = ST_FETCH;
               r_n.imem_req = 1'b1;
            end
            ST_FETCH: begin
               if (fetch.imem_ack) begin
                  r_n.state       = ST_HOLD;
                  r_n.imem_req    = 1'b0;
                  r_n.instr       = fetch.imem_data;
                  r_n.instr_valid = 1'b1;
                  r_n.pc_next     = pc_inc(r.pc);
                  r_n.pc          = pc_inc(r.pc);
               end
            end
            ST_HOLD: begin
               if (fetch.instr_ready) begin
                  r_n.instr_valid = 1'b0;
                  if (r.instr == HALT_WORD) begin
                     r_n.state    = ST_HALT;
                     r_n.halted   = 1'b1;
                     r_n.imem_req = 1'b0;
                  end else begin
                     r_n.state    = ST_FETCH;
                     r_n.imem_req = 1'b1;
                  end
               end
            end
            ST_HALT: begin
               r_n.imem_req    = 1'b0;
               r_n.instr_valid = 1'b0;
               r_n.halted      = 1'b1;
            end
         endcase
      end
   end

   // The PC register doubles as the fetch address.
   assign fetch.imem_req    = r.imem_req;
   assign fetch.imem_addr   = r.pc;
   assign fetch.instr       = r.instr;
   assign fetch.instr_valid = r.instr_valid;
   assign fetch.pc_next     = r.pc_next;
   assign fetch.halted      = r.halted;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_pc_fetch_stage;
   import pc_fetch_stage_pkg::*;

   localparam logic [31:0] HALT = 32'hFC00_0000;
   localparam logic [5:0]  RPC  = 6'd0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pc_fetch_stage_if bus();

   pc_fetch_stage #(
      .RESET_PC  (RPC),
      .HALT_WORD (HALT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .fetch (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Model: "started" after the first edge out of reset, "have an instruction"
   // for decode, "halted" once a halt word is accepted.
   bit          m_run    = 1'b0;
   bit          m_valid  = 1'b0;
   bit          m_halted = 1'b0;
   logic [5:0]  m_pc     = RPC;
   logic [5:0]  m_pcn    = 6'd0;
   logic [31:0] m_instr  = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input logic [5:0] j, input bit a,
                        input logic [31:0] d, input bit rdy);
      bus.redirect    = r;
      bus.pcj_out     = j;
      bus.imem_ack    = a;
      bus.imem_data   = d;
      bus.instr_ready = rdy;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run    <= 1'b0;
         m_valid  <= 1'b0;
         m_halted <= 1'b0;
         m_pc     <= RPC;
         m_pcn    <= 6'd0;
         m_instr  <= 32'd0;
      end else if (!m_run) begin
         m_run <= 1'b1;
      end else if (!m_halted) begin
         if (bus.redirect) begin
            m_pc    <= bus.pcj_out;
            m_valid <= 1'b0;
         end else if (!m_valid) begin
            if (bus.imem_ack) begin
               m_instr <= bus.imem_data;
               m_pcn   <= m_pc + 6'd4;
               m_pc    <= m_pc + 6'd4;
               m_valid <= 1'b1;
            end
         end else if (bus.instr_ready) begin
            m_valid  <= 1'b0;
            m_halted <= (m_instr == HALT);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("imem_req",    32'(bus.imem_req),    32'(m_run && !m_valid && !m_halted));
         check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
         check("instr",       bus.instr,            m_instr);
         check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
         check("pc_next",     32'(bus.pc_next),     32'(m_pcn));
         check("halted",      32'(bus.halted),      32'(m_halted));
      end
   end

   int          halt_cnt;
   logic [31:0] rnd_data;

   initial begin
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b0);
      repeat (2) @(negedge clk);

      check("rst_imem_req",  32'(bus.imem_req),    32'd0);
      check("rst_imem_addr", 32'(bus.imem_addr),   32'(RPC));
      check("rst_instr",     bus.instr,            32'd0);
      check("rst_valid",     32'(bus.instr_valid), 32'd0);
      check("rst_pc_next",   32'(bus.pc_next),     32'd0);
      check("rst_halted",    32'(bus.halted),      32'd0);
      cmp_en = 1'b1;

      // Basic fetch and accept.
      rst_n = 1'b1;
      @(negedge clk);
      check("first_req",  32'(bus.imem_req),  32'd1);
      check("first_addr", 32'(bus.imem_addr), 32'd0);
      drive(1'b0, 6'd0, 1'b1, 32'h2002_0005, 1'b1);
      @(negedge clk);
      check("first_instr", bus.instr,            32'h2002_0005);
      check("first_pcn",   32'(bus.pc_next),     32'd4);
      check("first_valid", 32'(bus.instr_valid), 32'd1);
      check("model_pcn",   32'(m_pcn),           32'd4);
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("second_addr", 32'(bus.imem_addr), 32'd4);
      check("second_req",  32'(bus.imem_req),  32'd1);

      // Decode stalls for five cycles.
      drive(1'b0, 6'd0, 1'b1, 32'h1234_5678, 1'b0);
      @(negedge clk);
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b0);
      repeat (5) begin
         check("hold_instr", bus.instr,            32'h1234_5678);
         check("hold_pcn",   32'(bus.pc_next),     32'd8);
         check("hold_req",   32'(bus.imem_req),    32'd0);
         check("hold_valid", 32'(bus.instr_valid), 32'd1);
         @(negedge clk);
      end
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("after_hold_addr", 32'(bus.imem_addr), 32'd8);
      check("after_hold_req",  32'(bus.imem_req),  32'd1);

      // Redirect beats a same-cycle ack.
      drive(1'b1, 6'd52, 1'b1, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk);
      check("redir_addr",  32'(bus.imem_addr),   32'd52);
      check("redir_valid", 32'(bus.instr_valid), 32'd0);
      check("redir_req",   32'(bus.imem_req),    32'd1);
      check("model_pc",    32'(m_pc),            32'd52);

      // PC wrap at 60.
      drive(1'b1, 6'd60, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      check("wrap_addr60", 32'(bus.imem_addr), 32'd60);
      drive(1'b0, 6'd0, 1'b1, 32'h0000_0ACE, 1'b0);
      @(negedge clk);
      check("wrap_pcn",   32'(bus.pc_next),     32'd0);
      check("wrap_valid", 32'(bus.instr_valid), 32'd1);
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("wrap_addr0", 32'(bus.imem_addr), 32'd0);
      check("wrap_req",   32'(bus.imem_req),  32'd1);

      // Halt word accepted; redirects and acks no longer matter.
      drive(1'b0, 6'd0, 1'b1, HALT, 1'b1);
      @(negedge clk);
      check("halt_instr", bus.instr,            HALT);
      check("halt_valid", 32'(bus.instr_valid), 32'd1);
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("halted",       32'(bus.halted),      32'd1);
      check("halted_req",   32'(bus.imem_req),    32'd0);
      check("halted_valid", 32'(bus.instr_valid), 32'd0);
      drive(1'b1, 6'd20, 1'b1, 32'h1111_1111, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("halt_redir_halted", 32'(bus.halted),   32'd1);
         check("halt_redir_req",    32'(bus.imem_req), 32'd0);
      end
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("halt_rst_addr",   32'(bus.imem_addr), 32'(RPC));
      check("halt_rst_halted", 32'(bus.halted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_req",  32'(bus.imem_req),  32'd1);
      check("restart_addr", 32'(bus.imem_addr), 32'(RPC));

      // Asynchronous reset in HOLD, with a late ack straddling it.
      drive(1'b0, 6'd0, 1'b1, 32'h0BAD_CAFE, 1'b0);
      @(negedge clk);
      check("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
      drive(1'b0, 6'd0, 1'b1, 32'h5555_AAAA, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("async_rst_valid", 32'(bus.instr_valid), 32'd0);
      check("async_rst_instr", bus.instr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("late_ack_valid", 32'(bus.instr_valid), 32'd0);
      check("late_ack_req",   32'(bus.imem_req),    32'd1);
      drive(1'b0, 6'd0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);

      // Randomized traffic; the compare process checks every cycle.
      halt_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         rnd_data = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
         drive($urandom_range(0, 11) == 0, 6'($urandom), $urandom_range(0, 1) == 1,
               rnd_data, $urandom_range(0, 9) < 6);
         if (m_halted) halt_cnt++;
         else          halt_cnt = 0;
         if (halt_cnt > 4 || $urandom_range(0, 249) == 0) begin
            #2 rst_n = 1'b0;
            #1 check("rnd_rst_valid", 32'(bus.instr_valid), 32'd0);
            check("rnd_rst_req", 32'(bus.imem_req), 32'd0);
            @(negedge clk);
            rst_n    = 1'b1;
            halt_cnt = 0;
         end else begin
            @(negedge clk);
         end
      end

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
